// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed little-endian word image over a byte stream
// and writes it into instruction RAM. Optional trailing XOR checksum via IMEM_BOOT_CHECKSUM_EN.
module imem_boot_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk_max,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data,
    output logic              mem_wren,
    output logic              core_reset,
    output logic              load_done,
    output logic              load_error
);

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
`ifdef IMEM_BOOT_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    // State entered once the image body is complete (empty image included).
`ifdef IMEM_BOOT_CHECKSUM_EN
    localparam state_t S_FINISH = S_CHECK;
`else
    localparam state_t S_FINISH = S_DONE;
`endif

    localparam logic [16:0] MAX_W17 = 17'(MAX_WORDS);

    state_t              r_state;
    state_t              w_state_next;
    logic [15:0]         r_count;
    logic [15:0]         r_word_cnt;
    logic [1:0]          r_byte_idx;
    logic [31:0]         r_data;
    logic [ADDR_W-1:0]   r_addr;
    logic                w_xfer;
    logic [15:0]         w_len;
    logic                w_last_word;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [7:0]          r_csum;
`endif

    assign mem_address = r_addr;
    assign mem_data    = r_data;
    assign w_len       = {rx_data, r_count[7:0]};
    assign w_last_word = ((r_word_cnt + 16'd1) == r_count);

    always_ff @(posedge clk_max) begin
        if (reset) begin
            r_state <= S_LEN_LO;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        rx_ready     = 1'b0;
        mem_wren     = 1'b0;
        core_reset   = 1'b1;
        load_done    = 1'b0;
        load_error   = 1'b0;
        w_xfer       = 1'b0;

        case (r_state)
            S_LEN_LO, S_LEN_HI, S_DATA: rx_ready = 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
            S_CHECK:                    rx_ready = 1'b1;
`endif
            default:                    rx_ready = 1'b0;
        endcase
        w_xfer = rx_valid & rx_ready;

        case (r_state)
            S_LEN_LO: begin
                if (w_xfer) w_state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_xfer) begin
                    if (w_len == 16'd0) begin
                        w_state_next = S_FINISH;
                    end else if ({1'b0, w_len} > MAX_W17) begin
                        w_state_next = S_ERROR;
                    end else begin
                        w_state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_xfer && (r_byte_idx == 2'd3)) w_state_next = S_WRITE;
            end
            S_WRITE: begin
                mem_wren     = 1'b1;
                w_state_next = w_last_word ? S_FINISH : S_DATA;
            end
`ifdef IMEM_BOOT_CHECKSUM_EN
            S_CHECK: begin
                if (w_xfer) w_state_next = ((r_csum ^ rx_data) == 8'h00) ? S_DONE : S_ERROR;
            end
`endif
            S_DONE: begin
                core_reset = 1'b0;
                load_done  = 1'b1;
            end
            S_ERROR: begin
                load_error = 1'b1;
            end
            default: w_state_next = S_LEN_LO;
        endcase
    end

    always_ff @(posedge clk_max) begin
        if (reset) begin
            r_count    <= '0;
            r_word_cnt <= '0;
            r_byte_idx <= '0;
            r_data     <= '0;
            r_addr     <= '0;
        end else begin
            case (r_state)
                S_LEN_LO: if (w_xfer) r_count[7:0]  <= rx_data;
                S_LEN_HI: if (w_xfer) r_count[15:8] <= rx_data;
                S_DATA: begin
                    if (w_xfer) begin
                        r_data[{r_byte_idx, 3'b000} +: 8] <= rx_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                    end
                end
                S_WRITE: begin
                    r_word_cnt <= r_word_cnt + 16'd1;
                    r_addr     <= r_addr + ADDR_W'(1);
                    r_byte_idx <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef IMEM_BOOT_CHECKSUM_EN
    always_ff @(posedge clk_max) begin
        if (reset) begin
            r_csum <= '0;
        end else if (w_xfer && (r_state != S_CHECK)) begin
            r_csum <= r_csum ^ rx_data;
        end
    end
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: frames, boundaries, back-pressure and mid-frame reset.
module tb_imem_boot_loader;

    logic        clk_max;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [9:0]  mem_address;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic        core_reset;
    logic        load_done;
    logic        load_error;

    int          n_tests;
    int          n_fail;
    int          wren_cnt;
    int          wren_base;
    logic [31:0] tb_mem [0:15];

    imem_boot_loader #(.ADDR_W(10), .MAX_WORDS(1024)) dut (
        .clk_max    (clk_max),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .mem_address(mem_address),
        .mem_data   (mem_data),
        .mem_wren   (mem_wren),
        .core_reset (core_reset),
        .load_done  (load_done),
        .load_error (load_error)
    );

    initial clk_max = 1'b0;
    always #5 clk_max = ~clk_max;

    // Capture RAM writes mid-cycle, away from the active edge.
    initial wren_cnt = 0;
    always @(negedge clk_max) begin
        if (mem_wren) begin
            wren_cnt = wren_cnt + 1;
            if (mem_address < 10'd16) tb_mem[mem_address[3:0]] = mem_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reset    = 1'b1;
        @(posedge clk_max);
        @(posedge clk_max);
        #1;
        reset     = 1'b0;
        wren_base = wren_cnt;
    endtask

    // Present a byte and hold it until accepted (bounded wait).
    task automatic send_byte(input logic [7:0] b);
        bit sent;
        sent     = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (rx_ready) begin
                @(posedge clk_max);
                #1;
                sent = 1'b1;
                break;
            end
            @(posedge clk_max);
            #1;
        end
        rx_valid = 1'b0;
        if (!sent) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_max);
            #1;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 16; i++) tb_mem[i] = 32'hDEAD_BEEF;

        do_reset();
        check("rst_rx_ready",   32'(rx_ready),    32'd1);
        check("rst_addr",       32'(mem_address), 32'd0);
        check("rst_data",       mem_data,         32'd0);
        check("rst_wren",       32'(mem_wren),    32'd0);
        check("rst_core_reset", 32'(core_reset),  32'd1);
        check("rst_done",       32'(load_done),   32'd0);
        check("rst_error",      32'(load_error),  32'd0);

        // Two-word image; 7th byte is offered during the WRITE cycle (back-pressure).
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("w0_wren",     32'(mem_wren),    32'd1);
        check("w0_addr",     32'(mem_address), 32'd0);
        check("w0_data",     mem_data,         32'h0000_0013);
        check("w0_rx_ready", 32'(rx_ready),    32'd0);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
`ifdef IMEM_BOOT_CHECKSUM_EN
        idle(1);
        send_byte(8'h92);
`endif
        idle(2);
        check("t1_wren_cnt",   32'(wren_cnt - wren_base), 32'd2);
        check("t1_mem0",       tb_mem[0], 32'h0000_0013);
        check("t1_mem1",       tb_mem[1], 32'h0010_0093);
        check("t1_done",       32'(load_done),   32'd1);
        check("t1_core_reset", 32'(core_reset),  32'd0);
        check("t1_rx_ready",   32'(rx_ready),    32'd0);
        check("t1_addr",       32'(mem_address), 32'd2);
        check("t1_wren_idle",  32'(mem_wren),    32'd0);

        // Empty image.
        do_reset();
        send_byte(8'h00); send_byte(8'h00);
`ifdef IMEM_BOOT_CHECKSUM_EN
        check("t2_wait_check", 32'(load_done), 32'd0);
        send_byte(8'h00);
`endif
        idle(2);
        check("t2_done",     32'(load_done),  32'd1);
        check("t2_core_rst", 32'(core_reset), 32'd0);
        check("t2_wren_cnt", 32'(wren_cnt - wren_base), 32'd0);

        // Count 1025 is one above the limit.
        do_reset();
        send_byte(8'h01); send_byte(8'h04);
        idle(2);
        check("t3_error",     32'(load_error), 32'd1);
        check("t3_core_rst",  32'(core_reset), 32'd1);
        check("t3_rx_ready",  32'(rx_ready),   32'd0);
        check("t3_done",      32'(load_done),  32'd0);
        rx_data = 8'h55; rx_valid = 1'b1;
        idle(4);
        rx_valid = 1'b0;
        check("t3_wren_cnt",  32'(wren_cnt - wren_base), 32'd0);
        check("t3_err_stick", 32'(load_error), 32'd1);

        // Count 1024 is exactly the limit and must be accepted.
        do_reset();
        send_byte(8'h00); send_byte(8'h04);
        check("t4_max_ready", 32'(rx_ready),   32'd1);
        check("t4_max_noerr", 32'(load_error), 32'd0);

        // Reset mid-frame, then reload.
        do_reset();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
        do_reset();
        check("t5_rst_ready", 32'(rx_ready),    32'd1);
        check("t5_rst_core",  32'(core_reset),  32'd1);
        check("t5_rst_data",  mem_data,         32'd0);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
`ifdef IMEM_BOOT_CHECKSUM_EN
        idle(1);
        send_byte(8'h01);
`endif
        idle(2);
        check("t5_mem0",     tb_mem[0], 32'hDDCC_BBAA);
        check("t5_wren_cnt", 32'(wren_cnt - wren_base), 32'd1);
        check("t5_done",     32'(load_done), 32'd1);

`ifdef IMEM_BOOT_CHECKSUM_EN
        do_reset();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        idle(1);
        send_byte(8'h05);
        idle(1);
        check("t6_csum_ok",   32'(load_done),  32'd1);
        do_reset();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        idle(1);
        send_byte(8'h06);
        idle(1);
        check("t6_csum_bad",  32'(load_error), 32'd1);
        check("t6_bad_core",  32'(core_reset), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
